// File: rtl/mont_pkg.sv
// Shared constants for the Montgomery exponentiation sequencer: default widths and FSM state codes.
package mont_pkg;

  localparam int unsigned MONT_WIDTH  = 1024;
  localparam int unsigned MONT_ELEN_W = 11;
  localparam int unsigned MUL_CNT_W   = 16;
  localparam int unsigned STATE_W     = 3;

  localparam logic [STATE_W-1:0] ST_IDLE     = 3'd0;
  localparam logic [STATE_W-1:0] ST_LOAD     = 3'd1;
  localparam logic [STATE_W-1:0] ST_SCAN     = 3'd2;
  localparam logic [STATE_W-1:0] ST_SQ_WAIT  = 3'd3;
  localparam logic [STATE_W-1:0] ST_MUL_WAIT = 3'd4;
  localparam logic [STATE_W-1:0] ST_FIN      = 3'd5;

endpackage

// File: rtl/mont_exp_bitscan.sv
// Exponent bit walker: MSB-first shift register plus remaining-bit counter.
// With MONT_EXP_SKIPZERO_EN defined it also flags the leading-zero run (leading=1 until the first 1 is consumed).
module mont_exp_bitscan
  import mont_pkg::*;
#(
  parameter int unsigned WIDTH  = MONT_WIDTH,
  parameter int unsigned ELEN_W = MONT_ELEN_W
) (
  input  logic              clk,
  input  logic              resetn,
  input  logic              load,
  input  logic              step,
  input  logic [WIDTH-1:0]  in_e,
  input  logic [ELEN_W-1:0] in_elen,
  output logic              cur_bit,
  output logic              last_bit,
  output logic              empty,
  output logic              leading
);

  localparam logic [ELEN_W-1:0] ELEN_MAX = ELEN_W'(WIDTH);

  logic [WIDTH-1:0]  e_sh;
  logic [ELEN_W-1:0] cnt;
  logic [ELEN_W-1:0] elen_sat;

  assign elen_sat = (in_elen > ELEN_MAX) ? ELEN_MAX : in_elen;

  // Align exponent bit elen-1 to the MSB so the walk is a plain left shift.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      e_sh <= '0;
      cnt  <= '0;
    end else if (load) begin
      e_sh <= in_e << (ELEN_MAX - elen_sat);
      cnt  <= elen_sat;
    end else if (step && (cnt != '0)) begin
      e_sh <= {e_sh[WIDTH-2:0], 1'b0};
      cnt  <= cnt - ELEN_W'(1);
    end
  end

  assign cur_bit  = e_sh[WIDTH-1];
  assign empty    = (cnt == '0);
  assign last_bit = (cnt == ELEN_W'(1));

`ifdef MONT_EXP_SKIPZERO_EN
  logic seen;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      seen <= 1'b0;
    end else if (load) begin
      seen <= 1'b0;
    end else if (step && (cnt != '0) && cur_bit) begin
      seen <= 1'b1;
    end
  end

  assign leading = ~seen & ~empty;
`else
  assign leading = 1'b0;
`endif

endmodule

// File: rtl/mont_exp_sequencer.sv
// Left-to-right square-and-multiply control for the Montgomery multiplier (start/done handshake).
// Optional MONT_EXP_SKIPZERO_EN: leading zero exponent bits are skipped and the first 1-bit loads acc=x.
module mont_exp_sequencer
  import mont_pkg::*;
#(
  parameter int unsigned WIDTH  = MONT_WIDTH,
  parameter int unsigned ELEN_W = MONT_ELEN_W
) (
  input  logic                 clk,
  input  logic                 resetn,
  input  logic                 start,
  input  logic [WIDTH-1:0]     in_x,
  input  logic [WIDTH-1:0]     in_r,
  input  logic [WIDTH-1:0]     in_m,
  input  logic [WIDTH-1:0]     in_e,
  input  logic [ELEN_W-1:0]    in_elen,
  output logic                 mul_start,
  output logic [WIDTH-1:0]     mul_a,
  output logic [WIDTH-1:0]     mul_b,
  output logic [WIDTH-1:0]     mul_m,
  input  logic [WIDTH-1:0]     mul_result,
  input  logic                 mul_done,
  output logic [WIDTH-1:0]     result,
  output logic                 done,
  output logic                 busy,
  output logic [MUL_CNT_W-1:0] mul_count
);

  logic [STATE_W-1:0]   state, state_nxt;
  logic [WIDTH-1:0]     acc, acc_nxt, x_q, x_nxt, m_nxt, a_nxt, b_nxt, result_nxt;
  logic                 bit_q, bit_nxt, mul_start_nxt, done_nxt, busy_nxt, fin;
  logic [MUL_CNT_W-1:0] cnt_nxt;
  logic                 scan_load, scan_step, cur_bit, last_bit, scan_empty, leading;

  mont_exp_bitscan #(.WIDTH(WIDTH), .ELEN_W(ELEN_W)) u_bitscan (
    .clk      (clk),
    .resetn   (resetn),
    .load     (scan_load),
    .step     (scan_step),
    .in_e     (in_e),
    .in_elen  (in_elen),
    .cur_bit  (cur_bit),
    .last_bit (last_bit),
    .empty    (scan_empty),
    .leading  (leading)
  );

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state     <= ST_IDLE;
      acc       <= '0;
      x_q       <= '0;
      mul_m     <= '0;
      mul_a     <= '0;
      mul_b     <= '0;
      bit_q     <= 1'b0;
      mul_start <= 1'b0;
      done      <= 1'b0;
      busy      <= 1'b0;
      result    <= '0;
      mul_count <= '0;
    end else begin
      state     <= state_nxt;
      acc       <= acc_nxt;
      x_q       <= x_nxt;
      mul_m     <= m_nxt;
      mul_a     <= a_nxt;
      mul_b     <= b_nxt;
      bit_q     <= bit_nxt;
      mul_start <= mul_start_nxt;
      done      <= done_nxt;
      busy      <= busy_nxt;
      result    <= result_nxt;
      mul_count <= cnt_nxt;
    end
  end

  // Operands only move on issue, so they stay frozen for the whole multiplier op.
  always_comb begin
    state_nxt     = state;
    acc_nxt       = acc;
    x_nxt         = x_q;
    m_nxt         = mul_m;
    a_nxt         = mul_a;
    b_nxt         = mul_b;
    bit_nxt       = bit_q;
    mul_start_nxt = 1'b0;
    done_nxt      = 1'b0;
    busy_nxt      = busy;
    result_nxt    = result;
    cnt_nxt       = mul_count;
    scan_load     = 1'b0;
    scan_step     = 1'b0;
    fin           = 1'b0;

    case (state)
      ST_IDLE: begin
        if (start) begin
          x_nxt     = in_x;
          m_nxt     = in_m;
          acc_nxt   = in_r;
          cnt_nxt   = '0;
          scan_load = 1'b1;
          busy_nxt  = 1'b1;
          state_nxt = ST_LOAD;
        end
      end
      ST_LOAD: begin
        if (scan_empty) fin = 1'b1;
        else            state_nxt = ST_SCAN;
      end
      ST_SCAN: begin
        scan_step = 1'b1;
        if (leading) begin
          if (cur_bit)  acc_nxt = x_q;
          if (last_bit) fin = 1'b1;
        end else begin
          bit_nxt       = cur_bit;
          a_nxt         = acc;
          b_nxt         = acc;
          mul_start_nxt = 1'b1;
          cnt_nxt       = mul_count + 16'd1;
          state_nxt     = ST_SQ_WAIT;
        end
      end
      ST_SQ_WAIT: begin
        if (mul_done) begin
          acc_nxt = mul_result;
          if (bit_q) begin
            a_nxt         = mul_result;
            b_nxt         = x_q;
            mul_start_nxt = 1'b1;
            cnt_nxt       = mul_count + 16'd1;
            state_nxt     = ST_MUL_WAIT;
          end else if (scan_empty) begin
            fin = 1'b1;
          end else begin
            state_nxt = ST_SCAN;
          end
        end
      end
      ST_MUL_WAIT: begin
        if (mul_done) begin
          acc_nxt = mul_result;
          if (scan_empty) fin = 1'b1;
          else            state_nxt = ST_SCAN;
        end
      end
      ST_FIN:  state_nxt = ST_IDLE;
      default: state_nxt = ST_IDLE;
    endcase

    // Entering FIN: done pulse and busy drop land in the same cycle as the new result.
    if (fin) begin
      state_nxt  = ST_FIN;
      done_nxt   = 1'b1;
      busy_nxt   = 1'b0;
      result_nxt = acc_nxt;
    end
  end

endmodule

// File: tb/tb_mont_exp_sequencer.sv
// Scoreboard bench for mont_exp_sequencer (WIDTH=16) with a behavioural Montgomery multiplier of random latency.
// Honours MONT_EXP_SKIPZERO_EN when computing expected multiplication counts.
module tb_mont_exp_sequencer;

  localparam int unsigned W  = 16;
  localparam int unsigned EW = 5;

  typedef struct {
    logic [W-1:0] res;
    logic [15:0]  cnt;
  } exp_t;

  logic          clk = 1'b0;
  logic          resetn;
  logic          start;
  logic [W-1:0]  in_x, in_r, in_m, in_e;
  logic [EW-1:0] in_elen;
  logic          mul_start;
  logic [W-1:0]  mul_a, mul_b, mul_m;
  logic [W-1:0]  mul_result;
  logic          mul_done;
  logic [W-1:0]  result;
  logic          done;
  logic          busy;
  logic [15:0]   mul_count;

  int   n_cmp = 0;
  int   n_err = 0;
  exp_t sb[$];
  int   lmin = 1;
  int   lmax = 20;
  int   starts_seen = 0;
  longint rinv_m = 0;
  longint rinv_y = 0;

  mont_exp_sequencer #(.WIDTH(W), .ELEN_W(EW)) dut (
    .clk        (clk),
    .resetn     (resetn),
    .start      (start),
    .in_x       (in_x),
    .in_r       (in_r),
    .in_m       (in_m),
    .in_e       (in_e),
    .in_elen    (in_elen),
    .mul_start  (mul_start),
    .mul_a      (mul_a),
    .mul_b      (mul_b),
    .mul_m      (mul_m),
    .mul_result (mul_result),
    .mul_done   (mul_done),
    .result     (result),
    .done       (done),
    .busy       (busy),
    .mul_count  (mul_count)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // R^-1 mod m for R = 2^16, found by search and cached per modulus.
  function automatic longint rinv(input longint m);
    if (m != rinv_m) begin
      rinv_m = m;
      rinv_y = 0;
      for (longint y = 1; y < m; y++) begin
        if ((y * 65536) % m == 1) begin
          rinv_y = y;
          break;
        end
      end
    end
    return rinv_y;
  endfunction

  function automatic longint mont_mul(input longint a, input longint b, input longint m);
    return (((a * b) % m) * rinv(m)) % m;
  endfunction

  // Expected outcome: (x_plain^e_eff) in Montgomery form, plus the multiplication count.
  function automatic exp_t golden(input logic [W-1:0] x, input logic [W-1:0] r, input logic [W-1:0] m,
                                  input logic [W-1:0] e, input logic [EW-1:0] elen);
    exp_t   o;
    int     n;
    longint ee, xp, p, mm;
    int     pop, msb;
    n  = (int'(elen) > 16) ? 16 : int'(elen);
    ee = (n == 0) ? 0 : (longint'(e) & ((longint'(1) << n) - 1));
    mm = longint'(m);
    pop = 0;
    msb = -1;
    for (int i = 0; i < 16; i++) begin
      if ((ee >> i) & 1) begin
        pop++;
        msb = i;
      end
    end
    if (ee == 0) begin
      o.res = r;
    end else begin
      xp = (longint'(x) * rinv(mm)) % mm;
      p  = 1;
      for (longint k = 0; k < ee; k++) p = (p * xp) % mm;
      o.res = W'((p * 65536) % mm);
    end
`ifdef MONT_EXP_SKIPZERO_EN
    o.cnt = (ee == 0) ? 16'd0 : 16'(msb + pop - 1);
`else
    o.cnt = 16'(n + pop);
`endif
    return o;
  endfunction

  // Behavioural multiplier: random latency, result computed from live inputs at done time.
  initial begin
    int left;
    bit pend;
    bit unstable;
    logic [W-1:0] a_l, b_l, m_l;
    mul_done   = 1'b0;
    mul_result = '0;
    pend = 0;
    left = 0;
    unstable = 0;
    a_l = '0; b_l = '0; m_l = '0;
    forever begin
      @(posedge clk); #1;
      mul_done = 1'b0;
      if (resetn !== 1'b1) begin
        pend = 0;
        continue;
      end
      if (pend) begin
        if (mul_a !== a_l || mul_b !== b_l || mul_m !== m_l || mul_start !== 1'b0) unstable = 1;
        left--;
        if (left == 0) begin
          chk("mul_operands_stable", 32'(unstable), 32'd0);
          mul_result = W'(mont_mul(longint'(mul_a), longint'(mul_b), longint'(mul_m)));
          mul_done   = 1'b1;
          pend       = 0;
        end
      end else if (mul_start === 1'b1) begin
        pend = 1;
        starts_seen++;
        left = $urandom_range(lmax, lmin);
        a_l = mul_a; b_l = mul_b; m_l = mul_m;
        unstable = 0;
      end
    end
  end

  // Monitor: every done pulse pops one expectation.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk); #1;
      if (done === 1'b1) begin
        if (sb.size() == 0) begin
          chk("unexpected_done", 32'd1, 32'd0);
        end else begin
          e = sb.pop_front();
          chk("result", 32'(result), 32'(e.res));
          chk("mul_count", 32'(mul_count), 32'(e.cnt));
        end
      end
    end
  end

  task automatic op(input logic [W-1:0] x, input logic [W-1:0] m, input logic [W-1:0] e,
                    input logic [EW-1:0] elen, input bit restart, output int lat);
    logic [W-1:0] r;
    r = W'(65536 % int'(m));
    sb.push_back(golden(x, r, m, e, elen));
    in_x = x; in_r = r; in_m = m; in_e = e; in_elen = elen;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    lat = 0;
    while (done !== 1'b1 && lat < 5000) begin
      if (restart && lat == 5) begin
        chk("busy_mid_run", 32'(busy), 32'd1);
        start = 1'b1;
        in_x = ~x; in_r = ~r; in_e = ~e; in_elen = 5'd1;
      end else begin
        start = 1'b0;
      end
      @(posedge clk); #1;
      lat++;
      if (restart && lat == 6) chk("busy_after_restart", 32'(busy), 32'd1);
    end
    start = 1'b0;
    if (lat >= 5000) begin
      chk("done_timeout", 32'd1, 32'd0);
    end else begin
      chk("busy_at_done", 32'(busy), 32'd0);
      @(posedge clk); #1;
      chk("done_one_cycle", 32'(done), 32'd0);
    end
  endtask

  initial begin
    int lat, s0, guard;
    logic [W-1:0] m, x;
    resetn = 1'b0;
    start = 1'b0;
    in_x = '0; in_r = '0; in_m = '0; in_e = '0; in_elen = '0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_mul_start", 32'(mul_start), 32'd0);
    chk("rst_result", 32'(result), 32'd0);
    chk("rst_mul_a", 32'(mul_a), 32'd0);
    chk("rst_mul_b", 32'(mul_b), 32'd0);
    chk("rst_mul_m", 32'(mul_m), 32'd0);
    chk("rst_mul_count", 32'(mul_count), 32'd0);
    resetn = 1'b1;
    @(posedge clk); #1;

    // elen=0: done in the third cycle counting the start cycle, no multiplier traffic.
    s0 = starts_seen;
    op(16'h1234, 16'hFFF1, 16'hBEEF, 5'd0, 1'b0, lat);
    chk("elen0_latency", 32'(lat), 32'd1);
    chk("elen0_no_mul_start", 32'(starts_seen - s0), 32'd0);

    x = W'($urandom_range(240, 0));
    op(x, 16'h00F1, 16'h000B, 5'd4, 1'b0, lat);
    op(16'h0777, 16'hC001, 16'h0000, 5'd16, 1'b0, lat);

    lmin = 1; lmax = 1;
    op(16'h2345, 16'hFFEF, 16'hFFFF, 5'd16, 1'b0, lat);
    lmin = 1; lmax = 20;

    // elen above WIDTH saturates to WIDTH.
    op(16'h0ABC, 16'hE00B, 16'h8421, 5'd31, 1'b0, lat);

    // A second start mid-run must be ignored.
    op(16'h0101, 16'hD2C5, 16'hA5A5, 5'd16, 1'b1, lat);

    // Reset while the multiply (second multiplier op) is in flight.
    lmin = 8; lmax = 8;
    s0 = starts_seen;
    in_x = 16'h0042; in_m = 16'hF00D; in_r = W'(65536 % 16'hF00D); in_e = 16'hFFFF; in_elen = 5'd16;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    guard = 0;
    while (starts_seen < s0 + 2 && guard < 2000) begin
      @(posedge clk); #2;
      guard++;
    end
    chk("reset_reach_mul_wait", 32'(guard < 2000), 32'd1);
    @(posedge clk); #2;
    resetn = 1'b0;
    #1;
    chk("midrst_busy", 32'(busy), 32'd0);
    chk("midrst_done", 32'(done), 32'd0);
    chk("midrst_mul_start", 32'(mul_start), 32'd0);
    chk("midrst_mul_count", 32'(mul_count), 32'd0);
    chk("midrst_result", 32'(result), 32'd0);
    @(posedge clk); #1;
    resetn = 1'b1;
    @(posedge clk); #1;
    lmin = 1; lmax = 20;
    op(16'h0042, 16'hF00D, 16'h00C3, 5'd8, 1'b0, lat);

    for (int i = 0; i < 12; i++) begin
      m = W'($urandom_range(65535, 3)) | 16'h0001;
      x = W'($urandom % int'(m));
      op(x, m, W'($urandom), EW'($urandom_range(20, 0)), 1'b0, lat);
    end

    repeat (3) @(posedge clk);
    #1;
    chk("scoreboard_drained", 32'(sb.size()), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_err);
    $finish;
  end

endmodule
